acc_datapath_seq: RTL

- Parametrised, self-sequencing accumulator processor. Datapath (IR, PC, accumulator A, add/sub unit, program/data RAM) plus its own fetch/decode/execute FSM.
- Next generation of the fixed 8-bit datapath:
  - width and memory depth are generic;
  - input is handshaked;
  - program RAM loads through a dedicated port while idle or halted.
- Sits at top of the processor under a testbench or board wrapper.

---
 rtl/acc_dp_pkg.sv | 25 ++
 rtl/acc_dp_ram.sv | 26 ++
 rtl/acc_datapath_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/acc_dp_pkg.sv
// Shared opcodes and FSM state encoding
// for the acc_datapath_seq accumulator core.
package acc_dp_pkg;

    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] OP_LOAD  = 3'b000;
    localparam logic [OPC_W-1:0] OP_STORE = 3'b001;
    localparam logic [OPC_W-1:0] OP_ADD   = 3'b010;
    localparam logic [OPC_W-1:0] OP_SUB   = 3'b011;
    localparam logic [OPC_W-1:0] OP_INPUT = 3'b100;
    localparam logic [OPC_W-1:0] OP_JZ    = 3'b101;
    localparam logic [OPC_W-1:0] OP_JPOS  = 3'b110;
    localparam logic [OPC_W-1:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_INWAIT,
        ST_HALT
    } state_t;

endpackage

// File: rtl/acc_dp_ram.sv
// Program/data RAM: synchronous write,
// asynchronous read, DATA_W x 2**ADDR_W.
module acc_dp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // single write port shared by program load and STORE
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/acc_datapath_seq.sv
// Self-sequencing accumulator processor: FSM, PC, IR, A, RAM.
// Optional sticky overflow flag: define ACC_DATAPATH_OVF_EN.
module acc_datapath_seq
    import acc_dp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              Aeq0,
    output logic              Apos,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out,
    output logic              ovf
);

    localparam logic [ADDR_W-1:0] PC_ONE = 1;
    localparam int MSB = DATA_W - 1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;

    logic [OPC_W-1:0]  w_opcode;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_raddr;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_idle;
    logic              w_prog_we;
    logic              w_store;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_opcode = r_ir[DATA_W-1 -: OPC_W];
    assign w_addr   = r_ir[ADDR_W-1:0];
    assign w_idle   = (r_state == ST_IDLE) || (r_state == ST_HALT);
    assign w_sum    = r_a + w_rdata;
    assign w_diff   = r_a - w_rdata;

    // FETCH reads at PC; every other state addresses the operand
    assign w_raddr = (r_state == ST_FETCH) ? r_pc : w_addr;

    // clear blocks both writers so a reset edge never touches RAM
    assign w_prog_we = prog_we && w_idle && !clear;
    assign w_store   = (r_state == ST_EXEC) && (w_opcode == OP_STORE)
                       && !clear;
    assign w_we      = w_prog_we || w_store;
    assign w_waddr   = w_store ? w_addr : prog_addr;
    assign w_wdata   = w_store ? r_a : prog_data;

    acc_dp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // fetch/decode/execute sequencer with PC, IR and accumulator
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_a     <= '0;
            r_ir    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        r_state <= ST_FETCH;
                        r_pc    <= '0;
                        r_a     <= '0;
                    end
                end
                ST_FETCH: begin
                    r_ir    <= w_rdata;
                    r_pc    <= r_pc + PC_ONE;
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (w_opcode == OP_HALT) begin
                        r_state <= ST_HALT;
                    end else if (w_opcode == OP_INPUT) begin
                        r_state <= ST_INWAIT;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_FETCH;
                    case (w_opcode)
                        OP_LOAD: r_a <= w_rdata;
                        OP_ADD:  r_a <= w_sum;
                        OP_SUB:  r_a <= w_diff;
                        OP_JZ:   if (Aeq0) r_pc <= w_addr;
                        OP_JPOS: if (Apos) r_pc <= w_addr;
                        default: ;
                    endcase
                end
                ST_INWAIT: begin
                    if (in_valid) begin
                        r_a     <= in_data;
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ACC_DATAPATH_OVF_EN
    logic r_ovf;
    logic w_ovf_add;
    logic w_ovf_sub;

    assign w_ovf_add = (r_a[MSB] == w_rdata[MSB])
                       && (w_sum[MSB] != r_a[MSB]);
    assign w_ovf_sub = (r_a[MSB] != w_rdata[MSB])
                       && (w_diff[MSB] != r_a[MSB]);

    // sticky signed overflow, re-armed by clear or a new run
    always_ff @(posedge clk) begin
        if (clear) begin
            r_ovf <= 1'b0;
        end else if (w_idle && start) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            if ((w_opcode == OP_ADD && w_ovf_add) ||
                (w_opcode == OP_SUB && w_ovf_sub)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign out_data = r_a;
    assign Aeq0     = (r_a == '0);
    assign Apos     = (r_a != '0) && !r_a[MSB];
    assign busy     = (r_state == ST_FETCH) || (r_state == ST_DECODE)
                      || (r_state == ST_EXEC) || (r_state == ST_INWAIT);
    assign halted   = (r_state == ST_HALT);
    assign in_ready = (r_state == ST_INWAIT);
    assign pc_out   = r_pc;

endmodule
